// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV64 M-extension unit: registered single-cycle multiply, radix-2 restoring
// divide, busy/valid handshake toward the hazard unit and EX/MEM latch, with flush abort.
module muldiv_sequencer #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DIV_CNT_W      = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inValid,
    output logic                      outReady,
    input  logic [2:0]                inOp,
    input  logic                      inWord,
    input  logic [BUS_DATA_WIDTH-1:0] inData1,
    input  logic [BUS_DATA_WIDTH-1:0] inData2,
    input  logic [4:0]                inDestRegister,
    input  logic                      inFlush,
    output logic                      outValid,
    input  logic                      inResultReady,
    output logic [BUS_DATA_WIDTH-1:0] outResult,
    output logic [4:0]                outDestRegister,
    output logic                      outBusy
);
    localparam int W  = BUS_DATA_WIDTH;
    localparam int HW = BUS_DATA_WIDTH / 2;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state;
    logic [2:0]           op;
    logic                 word;
    logic [4:0]           dest;
    logic [W-1:0]         mul_a;
    logic [W-1:0]         mul_b;
    logic [W-1:0]         rem_acc;
    logic [W-1:0]         quo;
    logic [W-1:0]         divisor;
    logic [DIV_CNT_W-1:0] count;
    logic                 neg_quo;
    logic                 neg_rem;
    logic                 special_case;

    function automatic logic [W-1:0] fit_word(input logic w, input logic [W-1:0] x);
        return w ? {{HW{x[HW-1]}}, x[HW-1:0]} : x;
    endfunction

    logic         accept;
    logic         acc_word;
    logic         acc_signed;
    logic         a_neg;
    logic         b_neg;
    logic         div_zero;
    logic         overflow;
    logic [W-1:0] div_a;
    logic [W-1:0] div_b;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;
    logic [W-1:0] special_val;

    // Operand conditioning at accept: W truncation/extension, magnitudes, special cases.
    always_comb begin
        accept     = inValid && outReady && !inFlush;
        acc_word   = inWord && (inOp == 3'b000 || inOp[2]);
        acc_signed = !inOp[0];
        div_a      = inData1;
        div_b      = inData2;
        if (acc_word) begin
            div_a = acc_signed ? {{HW{inData1[HW-1]}}, inData1[HW-1:0]}
                               : {{HW{1'b0}}, inData1[HW-1:0]};
            div_b = acc_signed ? {{HW{inData2[HW-1]}}, inData2[HW-1:0]}
                               : {{HW{1'b0}}, inData2[HW-1:0]};
        end
        a_neg    = acc_signed && div_a[W-1];
        b_neg    = acc_signed && div_b[W-1];
        a_mag    = a_neg ? -div_a : div_a;
        b_mag    = b_neg ? -div_b : div_b;
        div_zero = (div_b == '0);
        overflow = acc_signed && (div_b == '1) &&
                   (acc_word ? (div_a == {{(HW+1){1'b1}}, {(HW-1){1'b0}}})
                             : (div_a == {1'b1, {(W-1){1'b0}}}));
        special_val = '1;
        if (div_zero)
            special_val = inOp[1] ? div_a : '1;
        else if (overflow)
            special_val = inOp[1] ? '0 : div_a;
        special_val = fit_word(acc_word, special_val);
    end

    logic           mul_sa;
    logic           mul_sb;
    logic [2*W-1:0] prod;
    logic [W-1:0]   mul_res;
    logic [W:0]     shifted;
    logic [W-1:0]   diff;
    logic           ge;
    logic [W-1:0]   quo_raw;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   div_res;

    // Sign-extending both operands to 2W bits gives the exact signed/mixed/unsigned product.
    always_comb begin
        mul_sa  = (op == 3'b001 || op == 3'b010) && mul_a[W-1];
        mul_sb  = (op == 3'b001) && mul_b[W-1];
        prod    = {{W{mul_sa}}, mul_a} * {{W{mul_sb}}, mul_b};
        mul_res = (op[1:0] == 2'b00) ? fit_word(word, prod[W-1:0]) : prod[2*W-1:W];

        shifted = {rem_acc, quo[W-1]};
        ge      = shifted >= {1'b0, divisor};
        diff    = shifted[W-1:0] - divisor;

        quo_raw = word ? {{HW{1'b0}}, quo[HW-1:0]} : quo;
        quo_fix = neg_quo ? -quo_raw : quo_raw;
        rem_fix = neg_rem ? -rem_acc : rem_acc;
        div_res = special_case ? quo : fit_word(word, op[1] ? rem_fix : quo_fix);
    end

    // Control FSM plus datapath registers; special-case divides skip iteration with count 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            outValid        <= 1'b0;
            outResult       <= '0;
            outDestRegister <= '0;
            outBusy         <= 1'b0;
            outReady        <= 1'b1;
            count           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op       <= inOp;
                        word     <= acc_word;
                        dest     <= inDestRegister;
                        mul_a    <= inData1;
                        mul_b    <= inData2;
                        outReady <= 1'b0;
                        outBusy  <= 1'b1;
                        if (!inOp[2]) begin
                            state <= MUL;
                        end else begin
                            state   <= DIV;
                            rem_acc <= '0;
                            divisor <= b_mag;
                            neg_quo <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            if (div_zero || overflow) begin
                                special_case <= 1'b1;
                                count        <= '0;
                                quo          <= special_val;
                            end else begin
                                special_case <= 1'b0;
                                count        <= acc_word ? DIV_CNT_W'(HW) : DIV_CNT_W'(W);
                                quo          <= acc_word ? {a_mag[HW-1:0], {HW{1'b0}}} : a_mag;
                            end
                        end
                    end
                end
                MUL: begin
                    if (inFlush) begin
                        state    <= IDLE;
                        outReady <= 1'b1;
                        outBusy  <= 1'b0;
                    end else begin
                        state           <= DONE;
                        outResult       <= mul_res;
                        outDestRegister <= dest;
                        outValid        <= 1'b1;
                    end
                end
                DIV: begin
                    if (inFlush) begin
                        state    <= IDLE;
                        outReady <= 1'b1;
                        outBusy  <= 1'b0;
                        count    <= '0;
                    end else if (count != '0) begin
                        rem_acc <= ge ? diff : shifted[W-1:0];
                        quo     <= {quo[W-2:0], ge};
                        count   <= count - DIV_CNT_W'(1);
                    end else begin
                        state           <= DONE;
                        outResult       <= div_res;
                        outDestRegister <= dest;
                        outValid        <= 1'b1;
                    end
                end
                DONE: begin
                    if (inResultReady) begin
                        state    <= IDLE;
                        outValid <= 1'b0;
                        outReady <= 1'b1;
                        outBusy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus randomized operations
// compared against an arithmetic reference model of RV64 M-extension semantics.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic        outReady;
    logic [2:0]  inOp;
    logic        inWord;
    logic [63:0] inData1;
    logic [63:0] inData2;
    logic [4:0]  inDestRegister;
    logic        inFlush;
    logic        outValid;
    logic        inResultReady;
    logic [63:0] outResult;
    logic [4:0]  outDestRegister;
    logic        outBusy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.BUS_DATA_WIDTH(64), .DIV_CNT_W(7)) dut (
        .clk            (clk),
        .reset          (reset),
        .inValid        (inValid),
        .outReady       (outReady),
        .inOp           (inOp),
        .inWord         (inWord),
        .inData1        (inData1),
        .inData2        (inData2),
        .inDestRegister (inDestRegister),
        .inFlush        (inFlush),
        .outValid       (outValid),
        .inResultReady  (inResultReady),
        .outResult      (outResult),
        .outDestRegister(outDestRegister),
        .outBusy        (outBusy)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // RV64 M semantics from plain arithmetic: wide products, native / and %, special rules.
    function automatic logic [63:0] refModel(input logic [2:0] op, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
        logic               weff;
        logic               sgn;
        logic [31:0]        lo;
        logic signed [127:0] pa;
        logic signed [127:0] pb;
        logic signed [127:0] p;
        logic [63:0]        x;
        logic [63:0]        y;
        logic [63:0]        q;
        logic [63:0]        r;
        logic [63:0]        res;
        weff = w && (op == 3'b000 || op[2]);
        pa   = '0;
        pb   = '0;
        case (op)
            3'b000: begin
                lo  = a[31:0] * b[31:0];
                res = weff ? sext32(lo) : a * b;
            end
            3'b001: begin pa = $signed(a);    pb = $signed(b);    p = pa * pb; res = p[127:64]; end
            3'b010: begin pa = $signed(a);    pb = {64'd0, b};    p = pa * pb; res = p[127:64]; end
            3'b011: begin pa = {64'd0, a};    pb = {64'd0, b};    p = pa * pb; res = p[127:64]; end
            default: begin
                sgn = !op[0];
                x = weff ? (sgn ? sext32(a[31:0]) : {32'd0, a[31:0]}) : a;
                y = weff ? (sgn ? sext32(b[31:0]) : {32'd0, b[31:0]}) : b;
                if (y == 64'd0) begin
                    q = '1;
                    r = x;
                end else if (sgn && y == '1 &&
                             x == (weff ? sext32(32'h8000_0000) : 64'h8000_0000_0000_0000)) begin
                    q = x;
                    r = 64'd0;
                end else if (sgn) begin
                    q = $signed(x) / $signed(y);
                    r = $signed(x) % $signed(y);
                end else begin
                    q = x / y;
                    r = x % y;
                end
                res = op[1] ? r : q;
                if (weff) res = sext32(res[31:0]);
            end
        endcase
        return res;
    endfunction

    function automatic int expLatency(input logic [2:0] op, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
        logic weff;
        logic zero;
        logic ovf;
        if (!op[2]) return 2;
        weff = w;
        zero = weff ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = !op[0] && (weff ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                               : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (zero || ovf) return 2;
        return weff ? 34 : 66;
    endfunction

    // One full transaction: accept, wait for result with a bound, hold in DONE, release.
    task automatic applyStimulus(input logic [2:0] op, input logic w, input logic [63:0] a,
                                 input logic [63:0] b, input logic [4:0] rd, input int hold);
        logic [63:0] expected;
        int          cyc;
        expected = refModel(op, w, a, b);
        @(negedge clk);
        checkOutput("idle_ready", 64'(outReady), 64'd1);
        inValid = 1'b1; inOp = op; inWord = w; inData1 = a; inData2 = b; inDestRegister = rd;
        inResultReady = 1'b0;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0; inData1 = {$urandom(), $urandom()}; inData2 = {$urandom(), $urandom()};
        inDestRegister = 5'($urandom());
        cyc = 1;
        checkOutput("busy_after_accept", 64'(outBusy), 64'd1);
        checkOutput("ready_after_accept", 64'(outReady), 64'd0);
        while (!outValid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("latency", 64'(cyc), 64'(expLatency(op, w, a, b)));
        checkOutput("result", outResult, expected);
        checkOutput("dest", 64'(outDestRegister), 64'(rd));
        for (int i = 0; i < hold; i++) begin
            inFlush = 1'($urandom());
            inValid = 1'($urandom());
            @(negedge clk);
            checkOutput("hold_valid", 64'(outValid), 64'd1);
            checkOutput("hold_result", outResult, expected);
            checkOutput("hold_ready", 64'(outReady), 64'd0);
        end
        inFlush = 1'b0; inValid = 1'b0; inResultReady = 1'b1;
        @(negedge clk);
        inResultReady = 1'b0;
        checkOutput("release_valid", 64'(outValid), 64'd0);
        checkOutput("release_busy", 64'(outBusy), 64'd0);
        checkOutput("release_ready", 64'(outReady), 64'd1);
    endtask

    function automatic logic [63:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return '1;
            3:       return 64'h8000_0000_0000_0000;
            4:       return sext32(32'h8000_0000);
            5:       return 64'($urandom_range(0, 100));
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        logic [2:0] rop;
        logic       seen;
        reset = 1'b1; inValid = 1'b0; inOp = 3'd0; inWord = 1'b0; inData1 = '0; inData2 = '0;
        inDestRegister = '0; inFlush = 1'b0; inResultReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_valid", 64'(outValid), 64'd0);
        checkOutput("reset_result", outResult, 64'd0);
        checkOutput("reset_dest", 64'(outDestRegister), 64'd0);
        checkOutput("reset_busy", 64'(outBusy), 64'd0);
        checkOutput("reset_ready", 64'(outReady), 64'd1);

        applyStimulus(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 0);
        applyStimulus(3'b011, 1'b0, '1, 64'd2, 5'd2, 0);
        applyStimulus(3'b001, 1'b0, '1, 64'd2, 5'd3, 0);
        applyStimulus(3'b100, 1'b0, -64'sd20, 64'd6, 5'd4, 0);
        applyStimulus(3'b110, 1'b0, -64'sd20, 64'd6, 5'd5, 0);
        applyStimulus(3'b111, 1'b0, 64'd20, 64'd6, 5'd6, 5);
        applyStimulus(3'b100, 1'b1, 64'h1_0000_0010, 64'd5, 5'd7, 0);
        applyStimulus(3'b101, 1'b1, 64'hFFFF_FFFF, 64'd5, 5'd8, 0);
        applyStimulus(3'b100, 1'b0, 64'd42, 64'd0, 5'd9, 0);
        applyStimulus(3'b110, 1'b0, 64'd42, 64'd0, 5'd10, 0);
        applyStimulus(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd11, 0);
        applyStimulus(3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd12, 0);
        applyStimulus(3'b000, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_0001_0003, 5'd13, 1);

        // Flush at iteration 10 of a divide: back to idle, no result ever appears.
        @(negedge clk);
        inValid = 1'b1; inOp = 3'b100; inWord = 1'b0; inData1 = 64'd1000; inData2 = 64'd7;
        inDestRegister = 5'd14;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        repeat (9) @(negedge clk);
        inFlush = 1'b1;
        @(negedge clk);
        inFlush = 1'b0;
        checkOutput("flush_busy", 64'(outBusy), 64'd0);
        checkOutput("flush_ready", 64'(outReady), 64'd1);
        seen = outValid;
        repeat (80) begin
            @(negedge clk);
            seen |= outValid;
        end
        checkOutput("flush_no_valid", 64'(seen), 64'd0);

        // Flush in idle outranks a request.
        inValid = 1'b1; inFlush = 1'b1; inOp = 3'b000;
        @(negedge clk);
        inValid = 1'b0; inFlush = 1'b0;
        checkOutput("idle_flush_busy", 64'(outBusy), 64'd0);
        checkOutput("idle_flush_ready", 64'(outReady), 64'd1);

        // Reset (with a concurrent flush) in the middle of a divide clears every output.
        applyStimulus(3'b111, 1'b0, 64'd23, 64'd5, 5'd15, 0);
        @(negedge clk);
        inValid = 1'b1; inOp = 3'b101; inData1 = 64'd999; inData2 = 64'd4; inDestRegister = 5'd16;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1; inFlush = 1'b1;
        @(negedge clk);
        reset = 1'b0; inFlush = 1'b0;
        checkOutput("midreset_valid", 64'(outValid), 64'd0);
        checkOutput("midreset_result", outResult, 64'd0);
        checkOutput("midreset_dest", 64'(outDestRegister), 64'd0);
        checkOutput("midreset_busy", 64'(outBusy), 64'd0);
        checkOutput("midreset_ready", 64'(outReady), 64'd1);

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom());
            applyStimulus(rop, 1'($urandom()), pickOperand(), pickOperand(), 5'($urandom()),
                          int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle M-extension unit sitting beside the execute-stage ALU.
- Accepts MUL/DIV/REM class operations, including the W variants, from the decode/execute boundary after forwarding. Holds the pipeline through a busy handshake, computes the operation, and returns one 64-bit result to the EX/MEM latch.
- Division is iterative radix-2 restoring. Multiplication is a single-cycle product registered into a DONE state.

Parameters:
- BUS_DATA_WIDTH, 64, operand/result width
- DIV_CNT_W, 7, width of the iteration counter; must hold BUS_DATA_WIDTH

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- inValid  input  1  operation request
- outReady  output  1  unit can accept a request; high only in IDLE
- inOp  input  3  operation: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- inWord  input  1  W variant (mulw/divw/divuw/remw/remuw); valid only with inOp 000 or 1xx
- inData1  input  64  rs1 operand, already forwarded
- inData2  input  64  rs2 operand, already forwarded
- inDestRegister  input  5  rd, carried with the operation
- inFlush  input  1  abort the in-flight operation (branch mispredict)
- outValid  output  1  result available
- inResultReady  input  1  consumer takes the result
- outResult  output  64  result
- outDestRegister  output  5  rd of the result
- outBusy  output  1  high whenever state is not IDLE; the hazard unit stalls IF/ID/EX on it

Behaviour:
- Reset (synchronous, priority over everything, including a mid-division reset):
  - state = IDLE
  - outValid = 0, outResult = 0, outDestRegister = 0, outBusy = 0, counter = 0
  - outReady = 1 in the cycle after reset
- States: IDLE, MUL, DIV, DONE.
- Accept: inValid && outReady at a rising edge. Operands, op, word flag and rd are latched. Inputs are ignored in every other state.
- IDLE -> MUL: when inOp = 0xx.
  - MUL performs a full 128-bit product and goes to DONE the next cycle. Accept-to-outValid latency is 2 cycles.
  - mul: low 64 bits.
  - mulh: high 64 bits, signed x signed.
  - mulhsu: high 64 bits, signed x unsigned.
  - mulhu: high 64 bits, unsigned x unsigned.
  - mulw: low 32 bits of the 32x32 product, sign-extended to 64.
- IDLE -> DIV: when inOp = 1xx.
  - Signed ops use absolute values and fix the signs at completion: quotient negative if the operand signs differ; remainder takes the dividend's sign.
  - Iterations: 64, or 32 when inWord=1. One quotient bit per cycle; counter counts down to 0, then DONE.
  - Latency: 66 cycles (64-bit) or 34 cycles (W) from accept to outValid.
- Division special cases are resolved at accept time. The unit goes to DONE the next cycle, with latency 2 cycles.
  - Divisor 0: quotient = all ones (-1); remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1; 64- or 32-bit per inWord): quotient = dividend; remainder = 0.
- W variants:
  - Operands are truncated to [31:0], then sign-extended (signed ops) or zero-extended (unsigned ops) before computing.
  - The final 32-bit result is always sign-extended to 64, including divuw/remuw.
- DONE:
  - outValid = 1; outResult and outDestRegister are held stable.
  - Stays in DONE until inResultReady. On the inResultReady edge, goes to IDLE with outValid = 0.
  - A new request is accepted no earlier than the following cycle; there is no back-to-back accept.
- Flush:
  - inFlush in MUL or DIV: go to IDLE next edge; outValid is never asserted for the aborted op.
  - inFlush in DONE: has no effect; the result is already committed.
  - inFlush in IDLE: has priority over inValid; nothing is accepted that cycle.
- Simultaneous inFlush and reset: reset wins; the outcome is identical.

Test Plan:
- mul: inData1=7, inData2=-3 (0xFFFF_FFFF_FFFF_FFFD) -> 2 cycles later outValid=1, outResult=0xFFFF_FFFF_FFFF_FFEB, outBusy=1 for 2 cycles.
- mulhu: 0xFFFF_FFFF_FFFF_FFFF x 2 -> outResult=1. mulh of the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
- div: inData1=-20, inData2=6 -> outValid exactly 66 cycles after accept, quotient -3. rem with the same operands -> -2. remu 20 % 6 -> 2.
- divw: inData1=0x1_0000_0010 (low word 16), inData2=5 -> 34 cycles, outResult=3. divuw with inData1=0xFFFF_FFFF -> 0x0000_0000_3333_3333.
- Special cases:
  - div by 0 with inData1=42 -> 2 cycles, quotient 0xFFFF_FFFF_FFFF_FFFF.
  - rem by 0 -> 42.
  - div 0x8000_0000_0000_0000 / -1 -> quotient 0x8000_0000_0000_0000; rem -> 0.
- Handshake/abort:
  - Hold inResultReady=0 for 5 cycles after DONE -> result stable, outReady=0.
  - Assert inFlush at iteration 10 of a div -> IDLE next cycle, outValid never pulses.
  - Assert reset mid-div -> all outputs 0 next cycle.
